// File: rtl/jk_seq_driver.sv
// jk_seq_driver: prescaled hold/up/down/load sequencer that drives a JK cell bank
// using J/K pairs taken from the JK excitation table.
module jk_seq_driver #(
    parameter int WIDTH = 4,
    parameter int DIV   = 50000000,
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             Clear,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             tick_out,
    output logic             wrap,
    output logic             busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [DIV_W-1:0] cnt;
    logic [WIDTH-1:0] nxt, jn, kn;
    logic wn;
    always_comb begin
        nxt = mode == 2'b00 ? Q :
              mode == 2'b01 ? Q + WIDTH'(1) :
              mode == 2'b10 ? Q - WIDTH'(1) : load_val;
        // Excitation table with don't-cares forced to 0: J sets 0->1, K clears 1->0
        jn = ~Q & nxt;
        kn = Q & ~nxt;
        wn = (mode == 2'b01 && &Q) || (mode == 2'b10 && ~|Q);
    end
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            state    <= IDLE;
            cnt      <= '0;
            Q        <= '0;
            J        <= '0;
            K        <= '0;
            tick_out <= 1'b0;
            wrap     <= 1'b0;
            busy     <= 1'b0;
        end else if (state == IDLE) begin
            cnt      <= '0;
            tick_out <= 1'b0;
            wrap     <= 1'b0;
            if (start && !stop) begin
                state <= RUN;
                busy  <= 1'b1;
            end
        end else if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            J        <= '0;
            K        <= '0;
            tick_out <= 1'b0;
            wrap     <= 1'b0;
        end else if (cnt == DIV_W'(DIV - 1)) begin
            cnt      <= '0;
            tick_out <= 1'b1;
            wrap     <= wn;
            J        <= jn;
            K        <= kn;
            Q        <= (Q & ~kn) | (~Q & jn);
        end else begin
            cnt      <= cnt + DIV_W'(1);
            tick_out <= 1'b0;
            wrap     <= 1'b0;
        end
    end
endmodule
